// File: rtl/pipelined_adder_pkg.sv
// Shared constants and encodings for the pipelined adder.
//   DEFAULT_B  : default operand/result width in bits
//   MAX_STAGES : largest supported pipeline depth
//   mode_e     : operation select carried on the 'sub' input (ADD=0, SUB=1)
package pipelined_adder_pkg;

  localparam int DEFAULT_B  = 32;
  localparam int MAX_STAGES = 4;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } mode_e;

endpackage

// File: rtl/pipelined_adder_slice.sv
// One W-bit segment of the ripple-by-stage adder.
//   a, b     : segment operands (b already inverted for subtraction)
//   cin      : carry into the segment
//   sum      : segment sum modulo 2^W
//   cout     : carry out of the segment MSB
//   msb_cin  : carry into the segment MSB (XOR with cout gives signed overflow)
module adder_slice
  import pipelined_adder_pkg::*;
#(
  parameter int W = DEFAULT_B / 2
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         msb_cin
);

  logic [W:0] full;

  always_comb begin
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  end

  assign sum     = full[W-1:0];
  assign cout    = full[W];
  // The MSB sum bit is a^b^carry_in, so the carry into the MSB falls out by XOR.
  assign msb_cin = a[W-1] ^ b[W-1] ^ full[W-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined B-bit adder/subtractor, STAGES segments of W = B/STAGES bits.
//   clk, rst_n          : clock, asynchronous active-low reset
//   value1, value2, sub : operands and mode (0 add, 1 subtract)
//   in_valid, in_ready  : input handshake
//   flush               : drop every in-flight operation at the next edge
//   result, carry,
//   overflow            : sum/difference, unsigned carry (sub: 1 = no borrow),
//                         two's-complement overflow
//   out_valid, out_ready: output handshake
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The whole pipe advances together on en = !out_valid || out_ready,
// and in_ready is exactly en. While out_valid is high and out_ready low,
// every stage (outputs included) holds, so the outputs stay stable.
// flush clears the valid bits regardless of en, and an operand presented in
// the flush cycle is not captured.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int B      = DEFAULT_B,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [B-1:0] value1,
  input  logic [B-1:0] value2,
  input  logic         sub,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         flush,
  output logic [B-1:0] result,
  output logic         carry,
  output logic         overflow,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int W = B / STAGES;

  logic         en;
  logic [B-1:0] b_eff;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Subtraction is value1 + ~value2 + 1; the +1 enters as the carry into segment 0.
  assign b_eff = (sub == SUB) ? ~value2 : value2;

  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_stage
    // Width of the part of b that still has to be summed at this stage;
    // b is kept right-aligned so segment k always sits in the low W bits.
    localparam int BW = B - k * W;

    logic [B-1:0]  d_in;   // segments < k already summed, segments >= k still value1
    logic [BW-1:0] b_in;
    logic          c_in;
    logic          v_in;

    logic [W-1:0]  seg_sum;
    logic          seg_cout;
    logic          seg_msb_cin;
    logic [B-1:0]  d_out;

    logic [B-1:0]  d_q;
    logic          c_q;
    logic          v_q;

    if (k == 0) begin : g_first
      assign d_in = value1;
      assign b_in = b_eff;
      assign c_in = sub;
      assign v_in = in_valid;
    end else begin : g_next
      assign d_in = g_stage[k-1].d_q;
      assign b_in = g_stage[k-1].g_skew.b_q;
      assign c_in = g_stage[k-1].c_q;
      assign v_in = g_stage[k-1].v_q;
    end

    adder_slice #(
      .W (W)
    ) u_slice (
      .a       (d_in[k*W +: W]),
      .b       (b_in[W-1:0]),
      .cin     (c_in),
      .sum     (seg_sum),
      .cout    (seg_cout),
      .msb_cin (seg_msb_cin)
    );

    always_comb begin
      d_out           = d_in;
      d_out[k*W +: W] = seg_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
      end else if (flush) begin
        v_q <= 1'b0;
      end else if (en) begin
        v_q <= v_in;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        d_q <= '0;
        c_q <= 1'b0;
      end else if (en) begin
        d_q <= d_out;
        c_q <= seg_cout;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      // Upper, not-yet-summed part of b travels alongside the partial sum.
      logic [BW-W-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          b_q <= '0;
        end else if (en) begin
          b_q <= b_in[BW-1:W];
        end
      end
    end else begin : g_last
      logic ovf_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= seg_msb_cin ^ seg_cout;
        end
      end
    end
  end

  assign result    = g_stage[STAGES-1].d_q;
  assign carry     = g_stage[STAGES-1].c_q;
  assign overflow  = g_stage[STAGES-1].g_last.ovf_q;
  assign out_valid = g_stage[STAGES-1].v_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (B=32, STAGES=2).
module tb_pipelined_adder;
  import pipelined_adder_pkg::*;

  localparam int B      = 32;
  localparam int STAGES = 2;
  localparam int CLK_P  = 10;

  // ---------------- clock / reset ----------------
  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic [B-1:0] value1    = '0;
  logic [B-1:0] value2    = '0;
  logic         sub       = 1'b0;
  logic         in_valid  = 1'b0;
  logic         flush     = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready;
  logic [B-1:0] result;
  logic         carry;
  logic         overflow;
  logic         out_valid;

  always #(CLK_P/2) clk = ~clk;

  pipelined_adder #(
    .B      (B),
    .STAGES (STAGES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .value1    (value1),
    .value2    (value2),
    .sub       (sub),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .result    (result),
    .carry     (carry),
    .overflow  (overflow),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Packed as {overflow, carry, result}.
  function automatic logic [B+1:0] ref_model(input logic [B-1:0] a, input logic [B-1:0] b,
                                             input logic s);
    logic [B:0]   wide;
    logic [B-1:0] r;
    logic         c;
    logic         o;
    if (s) begin
      r = a - b;
      c = (a >= b);  // no borrow
      o = (a[B-1] != b[B-1]) && (r[B-1] != a[B-1]);
    end else begin
      wide = {1'b0, a} + {1'b0, b};
      r    = wide[B-1:0];
      c    = wide[B];
      o    = (a[B-1] == b[B-1]) && (r[B-1] != a[B-1]);
    end
    return {o, c, r};
  endfunction

  // ---------------- scoreboard ----------------
  logic [B+1:0] exp_q[$];
  logic [B+1:0] sb_exp;
  logic [B+1:0] hold_val;
  logic         hold_pend = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_pend) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", 64'({overflow, carry, result}), 64'(hold_val));
      end
      if (out_valid && exp_q.size() == 0) begin
        check("spurious_out", 64'(out_valid), 64'd0);
      end else if (out_valid && out_ready) begin
        sb_exp = exp_q.pop_front();
        check("result", 64'({overflow, carry, result}), 64'(sb_exp));
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(ref_model(value1, value2, sub));
      hold_pend = out_valid && !out_ready && !flush;
      hold_val  = {overflow, carry, result};
    end else begin
      hold_pend = 1'b0;
    end
  end

  // ---------------- out_ready driver ----------------
  // 0: driven by the main sequence, 1: 1,0,0,1 pattern, 2: random
  int   rdy_mode = 0;
  logic rdy_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int c = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) begin
        out_ready = rdy_pat[c % 4];
        c++;
      end else if (rdy_mode == 2) begin
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        c = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [B-1:0] a, input logic [B-1:0] b, input logic s);
    int n = 0;
    value1   = a;
    value2   = b;
    sub      = s;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Called just after the accepting edge with out_ready=1 and an empty pipe.
  task automatic finish_op(input string tag, input logic [B+1:0] expv);
    int lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(STAGES));
    check({tag, "_result"}, 64'(result), 64'(expv[B-1:0]));
    check({tag, "_carry"}, 64'(carry), 64'(expv[B]));
    check({tag, "_overflow"}, 64'(overflow), 64'(expv[B+1]));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [B-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h0000_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- directed vectors ----------------
  logic [B-1:0] d_a[5]   = '{32'h0000_FFFF, 32'h0000_0000, 32'h8000_0000,
                             32'h7FFF_FFFF, 32'hFFFF_FFFF};
  logic [B-1:0] d_b[5]   = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001,
                             32'h0000_0001, 32'h0000_0001};
  logic         d_s[5]   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  // {overflow, carry, result}
  logic [B+1:0] d_exp[5] = '{{1'b0, 1'b0, 32'h0001_0000},
                             {1'b0, 1'b0, 32'hFFFF_FFFF},
                             {1'b1, 1'b1, 32'h7FFF_FFFF},
                             {1'b1, 1'b0, 32'h8000_0000},
                             {1'b0, 1'b1, 32'h0000_0000}};

  // ---------------- main sequence ----------------
  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_outputs", 64'({overflow, carry, result}), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // First operand presented during reset is taken on the first edge after release.
    out_ready = 1'b1;
    value1    = d_a[0];
    value2    = d_b[0];
    sub       = d_s[0];
    in_valid  = 1'b1;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    finish_op("dir0", d_exp[0]);
    drain();

    for (int i = 1; i < 5; i++) begin
      send(d_a[i], d_b[i], d_s[i]);
      finish_op($sformatf("dir%0d", i), d_exp[i]);
      drain();
    end

    // Back-to-back stream under the 1,0,0,1 out_ready pattern
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) begin
      send($urandom, $urandom, 1'($urandom_range(0, 1)));
    end
    drain();
    rdy_mode  = 0;
    out_ready = 1'b1;

    // Random traffic with gaps and random back-pressure
    rdy_mode = 2;
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(pick_operand(), pick_operand(), ($urandom_range(0, 1) == 1) ? SUB : ADD);
    end
    drain();
    rdy_mode = 0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Flush: first op in flight, second op presented with flush -> both gone
    value1   = 32'h1234_5678;
    value2   = 32'h1111_1111;
    sub      = ADD;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    value1 = 32'h0F0F_0F0F;
    value2 = 32'h0101_0101;
    sub    = SUB;
    flush  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("flush_no_out", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
    end
    send(32'hDEAD_0000, 32'h0000_BEEF, ADD);
    finish_op("post_flush", ref_model(32'hDEAD_0000, 32'h0000_BEEF, ADD));
    drain();

    // Asynchronous reset mid-stream
    send(32'hAAAA_AAAA, 32'h5555_5555, ADD);
    send(32'h0000_0010, 32'h0000_0020, SUB);
    #3;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_outputs", 64'({overflow, carry, result}), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("post_rst_no_stale", 64'(out_valid), 64'd0);
    end
    send(32'hFFFF_0000, 32'h0001_0000, ADD);
    finish_op("post_rst", ref_model(32'hFFFF_0000, 32'h0001_0000, ADD));
    drain();

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #(CLK_P * 50000);
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 The block SHALL have parameter B, default 32: operand/result width in bits.
REQ-002 The block SHALL have parameter STAGES, default 2: number of pipeline stages; legal 1..4, and B SHALL be divisible by STAGES.
REQ-003 The block SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-005 The block SHALL have port value1  input  B: first operand.
REQ-006 The block SHALL have port value2  input  B: second operand.
REQ-007 The block SHALL have port sub  input  1: 0 = value1+value2, 1 = value1-value2.
REQ-008 The block SHALL have port in_valid  input  1: operands and sub valid this cycle.
REQ-009 The block SHALL have port in_ready  output  1: block accepts operands this cycle.
REQ-010 The block SHALL have port flush  input  1: discard all in-flight operations.
REQ-011 The block SHALL have port result  output  B: sum/difference modulo 2^B.
REQ-012 The block SHALL have port carry  output  1: unsigned carry-out; for sub, 1 = no borrow.
REQ-013 The block SHALL have port overflow  output  1: two's-complement signed overflow.
REQ-014 The block SHALL have port out_valid  output  1: result/carry/overflow valid.
REQ-015 The block SHALL have port out_ready  input  1: consumer accepts the result this cycle.

Function
REQ-016 Subtraction SHALL be computed as value1 + ~value2 + 1; the carry into segment 0 SHALL equal sub.
REQ-017 The operands SHALL be split into STAGES segments of W = B/STAGES bits; stage k SHALL add segment k with the registered carry from stage k-1, and segments not yet summed SHALL be skew-registered alongside.
REQ-018 Advance enable SHALL be en = !out_valid || out_ready; when en=1 every stage SHALL shift by one; when en=0 every stage register, including the outputs, SHALL hold.
REQ-019 in_ready SHALL equal en, combinationally; an operand SHALL be accepted when in_valid && in_ready.
REQ-020 Latency SHALL be exactly STAGES cycles from acceptance to out_valid with no back-pressure, and throughput SHALL be one result per cycle.
REQ-021 Results SHALL leave in acceptance order; there SHALL be no loss or duplication under any out_ready pattern.
REQ-022 overflow SHALL be the carry into the MSB XOR the carry out of the MSB, taken from the final stage.
REQ-023 Each stage SHALL carry a valid bit; a bubble (in_valid=0 with en=1) SHALL propagate as valid=0.
REQ-024 flush=1 SHALL clear all valid bits, including out_valid, at the next edge regardless of en; an operand presented in the same cycle as flush SHALL be dropped.
REQ-025 While out_valid=1, result, carry and overflow SHALL remain stable until the cycle in which out_ready=1.
REQ-026 With STAGES=1 the block SHALL be a single registered adder with the same handshake.

Reset
REQ-027 rst_n=0 SHALL asynchronously clear all valid bits, so that out_valid=0.
REQ-028 rst_n=0 SHALL clear result, carry and overflow to 0.
REQ-029 rst_n=0 SHALL clear all data, carry and skew registers to 0.
REQ-030 Deassertion of rst_n is synchronised externally; the first operand SHALL be accepted on the first edge after release.
REQ-031 An operation in flight when rst_n asserts SHALL be lost and SHALL never appear at the output.

Structure
REQ-032 A shared package SHALL hold the default width constant (32), the maximum STAGES (4), and the mode encodings ADD=0 / SUB=1.
REQ-033 Sub-module adder_slice (W-bit sum with carry-in and carry-out, plus MSB carry-in for overflow) SHALL be instantiated once per stage via generate.
REQ-034 No other sub-modules SHALL be used; handshake and skew logic SHALL be in pipelined_adder.

Verification
REQ-035 Scenario, B=32, STAGES=2, out_ready=1: 0x0000FFFF+0x00000001 -> after 2 cycles result=0x00010000, carry=0, overflow=0; verifies the cross-segment carry.
REQ-036 Scenario, sub=1: 0x00000000-0x00000001 -> result=0xFFFFFFFF, carry=0. Scenario, sub=1: 0x80000000-0x00000001 -> result=0x7FFFFFFF, overflow=1.
REQ-037 Scenario: 0x7FFFFFFF+0x00000001 -> result=0x80000000, overflow=1, carry=0. Scenario: 0xFFFFFFFF+0x00000001 -> result=0, carry=1.
REQ-038 Scenario: back-to-back stream of 8 random ops with out_ready toggling 1,0,0,1,... -> 8 results in order, each matching the reference model, with outputs held while out_ready=0.
REQ-039 Scenario: 2 ops in flight, flush pulsed for one cycle -> out_valid never asserts for them; the next op after flush completes normally in 2 cycles.
REQ-040 Scenario: rst_n pulsed low mid-stream, asynchronously between edges -> out_valid=0 and result=0 immediately; no stale result appears after release.
